alu_result_stage: RTL and testbench

// - Pipeline stage directly downstream of the 64-bit ALU. Registers ALU result + status into a small

---
 rtl/alu_pkg.sv | 8 +
 rtl/alu_result_fifo.sv | 52 +++++
 rtl/alu_result_stage.sv | 79 +++++++
 tb/tb_alu_result_stage.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: status-bit positions and the native result width.
package alu_pkg;
  localparam int FLAG_C     = 0;
  localparam int FLAG_Z     = 1;
  localparam int FLAG_O     = 2;
  localparam int FLAG_N     = 3;
  localparam int ALU_DATA_W = 64;
endpackage

// File: rtl/alu_result_fifo.sv
// In-order result buffer: storage array, wrapping pointers, occupancy count and flush.
module alu_result_fifo #(
  parameter int W     = 69,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [W-1:0]     wdata_i,
  output logic [W-1:0]     rdata_o,
  output logic [CNT_W-1:0] count_o
);
  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  // A flushed cycle neither admits nor retires anything.
  assign do_push = push_i & ~flush_i & (count_q != CNT_W'(DEPTH));
  assign do_pop  = pop_i  & ~flush_i & (count_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

// File: rtl/alu_result_stage.sv
// Result stage behind the ALU: buffers results for the consumer and owns the
// architectural status register {N,O,Z,C} plus the sticky overflow bit.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int DATA_W = ALU_DATA_W,
  parameter int DEST_W = 5,
  parameter int DEPTH  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [3:0]        in_status,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_setflags,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [DEST_W-1:0] out_dest,
  output logic [3:0]        flags_q,
  output logic              ovf_sticky,
  input  logic              sticky_clr,
  input  logic              flush
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ENT_W = DATA_W + DEST_W;

  logic [CNT_W-1:0] count;
  logic [ENT_W-1:0] head;
  logic [ENT_W-1:0] hold_q, hold_d;
  logic [3:0]       flags_d;
  logic             sticky_q, sticky_d;
  logic             push, pop, accept;

  // Handshakes depend only on the registered count, so no in->out or out_ready->in_ready path.
  assign in_ready  = (count != CNT_W'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign accept    = push & ~flush;

  alu_result_fifo #(
    .W     (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_dest, in_data}),
    .rdata_o (head),
    .count_o (count)
  );

  always_comb begin
    flags_d  = (accept & in_setflags) ? in_status : flags_q;
    sticky_d = (sticky_q & ~sticky_clr) | (accept & in_setflags & in_status[FLAG_O]);
    hold_d   = (pop & ~flush) ? head : hold_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q  <= 4'b0000;
      sticky_q <= 1'b0;
      hold_q   <= '0;
    end else begin
      flags_q  <= flags_d;
      sticky_q <= sticky_d;
      hold_q   <= hold_d;
    end
  end

  // When empty, the outputs keep showing the most recently retired entry.
  assign {out_dest, out_data} = out_valid ? head : hold_q;
  assign ovf_sticky           = sticky_q;
endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios followed by random traffic, each
// cycle compared against a queue-based reference model.
module tb_alu_result_stage;
  localparam int DATA_W = 64;
  localparam int DEST_W = 5;
  localparam int DEPTH  = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic [3:0]        in_status = '0;
  logic [DEST_W-1:0] in_dest = '0;
  logic              in_setflags = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [DEST_W-1:0] out_dest;
  logic [3:0]        flags_q;
  logic              ovf_sticky;
  logic              sticky_clr = 1'b0;
  logic              flush = 1'b0;

  always #5 clk = ~clk;

  alu_result_stage #(.DATA_W(DATA_W), .DEST_W(DEST_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_status(in_status), .in_dest(in_dest),
    .in_setflags(in_setflags), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_dest(out_dest), .flags_q(flags_q),
    .ovf_sticky(ovf_sticky), .sticky_clr(sticky_clr), .flush(flush)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [DEST_W-1:0] dest;
  } ent_t;

  ent_t       q[$];
  ent_t       last_m;
  logic [3:0] flags_m;
  logic       sticky_m;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    last_m.data = '0;
    last_m.dest = '0;
    flags_m     = 4'b0000;
    sticky_m    = 1'b0;
  endtask

  task automatic check_all(input string tag);
    ent_t shown;
    shown = (q.size() != 0) ? q[0] : last_m;
    chk({tag, ".out_valid"},  64'(out_valid),  64'(q.size() != 0));
    chk({tag, ".in_ready"},   64'(in_ready),   64'(q.size() < DEPTH));
    chk({tag, ".out_data"},   out_data,        shown.data);
    chk({tag, ".out_dest"},   64'(out_dest),   64'(shown.dest));
    chk({tag, ".flags_q"},    64'(flags_q),    64'(flags_m));
    chk({tag, ".ovf_sticky"}, 64'(ovf_sticky), 64'(sticky_m));
  endtask

  // Advance one clock: predict from the inputs presented now, then compare after the edge.
  task automatic cycle(input string tag);
    bit   rdy, vld, push, pop, acc;
    ent_t e;
    rdy    = (q.size() < DEPTH);
    vld    = (q.size() > 0);
    push   = in_valid && rdy;
    pop    = vld && out_ready;
    acc    = push && !flush;
    e.data = in_data;
    e.dest = in_dest;
    sticky_m = (sticky_m && !sticky_clr) || (acc && in_setflags && in_status[2]);
    if (acc && in_setflags) flags_m = in_status;
    if (flush) q.delete();
    else begin
      if (pop) last_m = q.pop_front();
      if (push) q.push_back(e);
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drv(input logic v, input logic [63:0] d, input logic [4:0] t,
                     input logic [3:0] s, input logic sf);
    in_valid    = v;
    in_data     = d;
    in_dest     = t;
    in_status   = s;
    in_setflags = sf;
  endtask

  task automatic idle();
    drv(1'b0, 64'h0, 5'd0, 4'h0, 1'b0);
    sticky_clr = 1'b0;
    flush      = 1'b0;
  endtask

  initial begin
    model_reset();
    #1;
    check_all("reset");
    chk("reset.out_data_zero", out_data, 64'h0);
    #20 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push, visible one cycle later
    drv(1'b1, 64'hDEAD_BEEF, 5'd3, 4'b1000, 1'b1);
    out_ready = 1'b1;
    cycle("single_push");
    chk("single_push.flags_const", 64'(flags_q), 64'h8);
    chk("single_push.data_const", out_data, 64'hDEAD_BEEF);
    idle();
    cycle("single_pop");
    chk("empty_hold.data_const", out_data, 64'hDEAD_BEEF);

    // Backpressure: three pushes, two accepted
    out_ready = 1'b0;
    drv(1'b1, 64'h1111, 5'd1, 4'b0000, 1'b0); cycle("bp_push0");
    drv(1'b1, 64'h2222, 5'd2, 4'b0000, 1'b0); cycle("bp_push1");
    chk("bp.in_ready_low", 64'(in_ready), 64'h0);
    drv(1'b1, 64'h3333, 5'd3, 4'b0000, 1'b0); cycle("bp_push2_rejected");
    idle();
    out_ready = 1'b1;
    cycle("bp_pop0");
    chk("bp.in_ready_back", 64'(in_ready), 64'h1);
    chk("bp.second_head", out_data, 64'h2222);
    cycle("bp_pop1");

    // Full with simultaneous push attempt and pop
    out_ready = 1'b0;
    drv(1'b1, 64'hA0, 5'd10, 4'b0000, 1'b0); cycle("full_fill0");
    drv(1'b1, 64'hA1, 5'd11, 4'b0000, 1'b0); cycle("full_fill1");
    drv(1'b1, 64'hA2, 5'd12, 4'b0000, 1'b0);
    out_ready = 1'b1;
    cycle("full_push_pop");
    chk("full_push_pop.head", out_data, 64'hA1);
    idle();
    cycle("full_drain");

    // Sticky overflow: set beats clear, then clear alone, then non-flag push
    drv(1'b1, 64'h55, 5'd5, 4'b0100, 1'b1);
    sticky_clr = 1'b1;
    cycle("sticky_set_wins");
    chk("sticky_set_wins.const", 64'(ovf_sticky), 64'h1);
    idle();
    sticky_clr = 1'b1;
    cycle("sticky_clear");
    chk("sticky_clear.const", 64'(ovf_sticky), 64'h0);
    idle();
    drv(1'b1, 64'h66, 5'd6, 4'b1111, 1'b0);
    cycle("noflag_push");
    chk("noflag_push.flags_const", 64'(flags_q), 64'h4);
    idle();
    cycle("noflag_drain");

    // Flush with two entries, then flush with room so the push is truly dropped
    out_ready = 1'b0;
    drv(1'b1, 64'hF0, 5'd7, 4'b0000, 1'b0); cycle("flush_fill0");
    drv(1'b1, 64'hF1, 5'd8, 4'b0000, 1'b0); cycle("flush_fill1");
    drv(1'b1, 64'hF2, 5'd9, 4'b1011, 1'b1);
    flush = 1'b1;
    out_ready = 1'b1;
    cycle("flush_full");
    idle();
    out_ready = 1'b0;
    drv(1'b1, 64'hE0, 5'd4, 4'b0000, 1'b0); cycle("flush2_fill");
    drv(1'b1, 64'hE1, 5'd5, 4'b1001, 1'b1);
    flush = 1'b1;
    cycle("flush_drop_push");
    chk("flush_drop_push.flags_const", 64'(flags_q), 64'h4);
    idle();
    cycle("after_flush");

    // Random traffic with an asynchronous reset pulse in the middle
    for (int i = 0; i < 400; i++) begin
      drv(1'($urandom), {$urandom, $urandom}, 5'($urandom), 4'($urandom), 1'($urandom));
      out_ready  = ($urandom_range(0, 2) != 0);
      sticky_clr = ($urandom_range(0, 7) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      cycle("rand");
      if (i == 200) begin
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("rst_mid");
        #2 rst_n = 1'b1;
        idle();
        out_ready = 1'b0;
        cycle("post_rst");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
